control_unit: RTL and testbench

- Hardwired Moore control sequencer for the SRC-style datapath.
- Sits directly upstream of the datapath. It drives every bus-select, register-load and memory strobe that the datapath otherwise takes from a bench.
- It reads the IR and CON back from the datapath.
- Each control step T0..T7 lasts exactly one Clock cycle.

---
 rtl/src_ctrl_pkg.sv | 101 ++++++++++
 rtl/control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_control_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the SRC control sequencer: opcodes, state encodings,
// ALU op codes and the control-word layout.
package src_ctrl_pkg;

    localparam int OPC_W   = 5;
    localparam int ALUOP_W = 5;
    localparam int IR_W    = 32;
    localparam int STATE_W = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10101;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // The ALU consumes the arithmetic opcodes directly.
    localparam logic [ALUOP_W-1:0] ALU_ADD = OP_ADD;
    localparam logic [ALUOP_W-1:0] ALU_SUB = OP_SUB;
    localparam logic [ALUOP_W-1:0] ALU_AND = OP_AND;
    localparam logic [ALUOP_W-1:0] ALU_OR  = OP_OR;

    typedef enum logic [STATE_W-1:0] {
        S_RST  = 5'd0,
        S_T0   = 5'd1,
        S_T1   = 5'd2,
        S_T2   = 5'd3,
        S_T3   = 5'd4,
        S_T4   = 5'd5,
        S_T5   = 5'd6,
        S_T6   = 5'd7,
        S_T7   = 5'd8,
        S_HALT = 5'd9
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic zhi_out;
        logic zlo_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic con_in;
        logic outport_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } ctrl_t;

    // Final control step of each instruction; nop and unassigned codes end at fetch.
    function automatic state_t last_step(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
            OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  return S_T5;
            OP_LD, OP_ST:                              return S_T7;
            OP_MUL, OP_DIV, OP_BR:                     return S_T6;
            OP_NEG, OP_NOT, OP_JAL:                    return S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:    return S_T3;
            default:                                   return S_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the SRC datapath: steps T0..T7 and
// decodes every bus, load and memory strobe from state plus registered opcode.
//
// state  | meaning
// RST    | held in reset, all controls low
// T0-T2  | instruction fetch
// T3-T7  | execute steps, decoded from the registered opcode
// HALT   | stopped until Reset, all controls low
module control_unit
    import src_ctrl_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stop,
    input  logic [IR_W-1:0]    IR,
    input  logic               CON,
    output logic               PCout,
    output logic               ZHIout,
    output logic               ZLOout,
    output logic               MDRout,
    output logic               HIout,
    output logic               LOout,
    output logic               INPORTout,
    output logic               Cout,
    output logic               BAout,
    output logic               Rout,
    output logic               PCin,
    output logic               IRin,
    output logic               MARin,
    output logic               MDRin,
    output logic               Yin,
    output logic               Zin,
    output logic               HIin,
    output logic               LOin,
    output logic               CONin,
    output logic               OUTPORTin,
    output logic               Rin,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               Run
);

    state_t             state_q, state_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [OPC_W-1:0]   ir_opc;
    logic               unused_ir;
    ctrl_t              ctl;
    logic [ALUOP_W-1:0] alu_op;
    logic               run;

    assign ir_opc    = IR[IR_W-1:IR_W-OPC_W];
    assign unused_ir = ^IR[IR_W-OPC_W-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_RST;
            opc_q   <= OP_NOP;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // The decision leaving T2 uses the live IR because opc_q is only captured on that edge.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2: begin
                opc_d = ir_opc;
                if (ir_opc == OP_HALT)
                    state_d = S_HALT;
                else if (last_step(ir_opc) == S_T2)
                    state_d = Stop ? S_HALT : S_T0;
                else
                    state_d = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_step(opc_q))
                    state_d = Stop ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + STATE_W'(1));
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        ctl    = '0;
        alu_op = ALU_ADD;
        run    = 1'b1;
        case (state_q)
            S_T0: begin
                ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
            end
            S_T1: begin
                ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
            end
            S_T3: begin
                case (opc_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                    OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = opc_q;
                    end
                    OP_BR:   begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
                    OP_JR:   begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                    OP_IN:   begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                    OP_OUT:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
                    OP_MFHI: begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                    OP_MFLO: begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                    OP_JAL:  begin ctl.pc_out = 1'b1; ctl.grb = 1'b1; ctl.r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opc_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                        ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = opc_q;
                    end
                    OP_ADDI, OP_LD, OP_LDI, OP_ST: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; end
                    OP_ANDI: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; alu_op = ALU_AND; end
                    OP_ORI:  begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; alu_op = ALU_OR; end
                    OP_MUL, OP_DIV: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = opc_q;
                    end
                    OP_NEG, OP_NOT: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                    OP_BR:   begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
                    OP_JAL:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opc_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                    OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    OP_LD, OP_ST:   begin ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1; end
                    OP_MUL, OP_DIV: begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
                    OP_BR:          begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opc_q)
                    OP_LD:          begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
                    OP_ST:          begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
                    OP_MUL, OP_DIV: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
                    OP_BR:          begin ctl.zlo_out = 1'b1; ctl.pc_in = CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opc_q)
                    OP_LD:   begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                    OP_ST:   ctl.write = 1'b1;
                    default: ;
                endcase
            end
            default: begin
                alu_op = '0;
                run    = 1'b0;
            end
        endcase
    end

    assign PCout     = ctl.pc_out;
    assign ZHIout    = ctl.zhi_out;
    assign ZLOout    = ctl.zlo_out;
    assign MDRout    = ctl.mdr_out;
    assign HIout     = ctl.hi_out;
    assign LOout     = ctl.lo_out;
    assign INPORTout = ctl.inport_out;
    assign Cout      = ctl.c_out;
    assign BAout     = ctl.ba_out;
    assign Rout      = ctl.r_out;
    assign PCin      = ctl.pc_in;
    assign IRin      = ctl.ir_in;
    assign MARin     = ctl.mar_in;
    assign MDRin     = ctl.mdr_in;
    assign Yin       = ctl.y_in;
    assign Zin       = ctl.z_in;
    assign HIin      = ctl.hi_in;
    assign LOin      = ctl.lo_in;
    assign CONin     = ctl.con_in;
    assign OUTPORTin = ctl.outport_in;
    assign Rin       = ctl.r_in;
    assign Gra       = ctl.gra;
    assign Grb       = ctl.grb;
    assign Grc       = ctl.grc;
    assign IncPC     = ctl.inc_pc;
    assign Read      = ctl.read;
    assign Write     = ctl.write;
    assign AluOp     = alu_op;
    assign Run       = run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand-written halt/stop/reset
// sequences, then random instructions checked against a per-opcode microprogram.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset, Stop, CON;
    logic [31:0] IR;
    logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout, BAout, Rout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [4:0] AluOp;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON(CON),
        .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .CONin(CONin), .OUTPORTin(OUTPORTin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .AluOp(AluOp),
        .Run(Run)
    );

    always #5 Clock = ~Clock;

    logic [26:0] act;
    assign act = {Write, Read, IncPC, Grc, Grb, Gra, Rin, OUTPORTin, CONin, LOin,
                  HIin, Zin, Yin, MDRin, MARin, IRin, PCin, Rout, BAout, Cout,
                  INPORTout, LOout, HIout, MDRout, ZLOout, ZHIout, PCout};

    localparam logic [26:0] M_PCOUT  = 27'd1 << 0,  M_ZHIOUT  = 27'd1 << 1;
    localparam logic [26:0] M_ZLOOUT = 27'd1 << 2,  M_MDROUT  = 27'd1 << 3;
    localparam logic [26:0] M_HIOUT  = 27'd1 << 4,  M_LOOUT   = 27'd1 << 5;
    localparam logic [26:0] M_INPOUT = 27'd1 << 6,  M_COUT    = 27'd1 << 7;
    localparam logic [26:0] M_BAOUT  = 27'd1 << 8,  M_ROUT    = 27'd1 << 9;
    localparam logic [26:0] M_PCIN   = 27'd1 << 10, M_IRIN    = 27'd1 << 11;
    localparam logic [26:0] M_MARIN  = 27'd1 << 12, M_MDRIN   = 27'd1 << 13;
    localparam logic [26:0] M_YIN    = 27'd1 << 14, M_ZIN     = 27'd1 << 15;
    localparam logic [26:0] M_HIIN   = 27'd1 << 16, M_LOIN    = 27'd1 << 17;
    localparam logic [26:0] M_CONIN  = 27'd1 << 18, M_OUTPIN  = 27'd1 << 19;
    localparam logic [26:0] M_RIN    = 27'd1 << 20, M_GRA     = 27'd1 << 21;
    localparam logic [26:0] M_GRB    = 27'd1 << 22, M_GRC     = 27'd1 << 23;
    localparam logic [26:0] M_INCPC  = 27'd1 << 24, M_READ    = 27'd1 << 25;
    localparam logic [26:0] M_WRITE  = 27'd1 << 26;

    localparam logic [26:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [26:0] F1 = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [26:0] F2 = M_MDROUT | M_IRIN;
    localparam logic [4:0]  ADD = 5'b00011;

    localparam logic [31:0] ORI_IR  = 32'h71180025;
    localparam logic [31:0] LD_IR   = 32'h00900054;
    localparam logic [31:0] BR_IR   = 32'h9A80000E;
    localparam logic [31:0] HALT_IR = 32'hD8000000;
    localparam logic [31:0] ADD_IR  = 32'h18000000;

    int vectors    = 0;
    int miscompares = 0;

    // Microprogram model: control word per step T0..T7 for each opcode.
    typedef struct packed {
        logic [26:0] ctl;
        logic [4:0]  alu;
        logic        pc_if_con;
    } ustep_t;
    ustep_t prog [32][8];
    int     plen [32];

    typedef struct packed {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [26:0] ctl;
        logic [4:0]  alu;
        logic        run;
    } vec_t;
    vec_t vt [64];
    int   nv = 0;

    task automatic step(input logic [31:0] ir, input logic con, input logic stop,
                        input logic [26:0] ec, input logic [4:0] ea, input logic er,
                        input string nm);
        IR = ir; CON = con; Stop = stop;
        @(negedge Clock);
        vectors++;
        if (act !== ec || AluOp !== ea || Run !== er) begin
            miscompares++;
            $display("FAIL %s: got ctl=%07h alu=%05b run=%0b, expected ctl=%07h alu=%05b run=%0b",
                     nm, act, AluOp, Run, ec, ea, er);
        end
        @(posedge Clock); #1;
    endtask

    task automatic idle(input string nm);
        step($urandom, 1'($urandom), 1'($urandom), 27'd0, 5'd0, 1'b0, nm);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        @(posedge Clock); #1;
        repeat (n - 1) idle("reset_hold");
        Reset = 1'b0;
        idle("reset_release");
    endtask

    task automatic ps(input int o, input int k, input logic [26:0] c, input logic [4:0] a);
        prog[o][k].ctl = c;
        prog[o][k].alu = a;
    endtask

    task automatic add_vec(input logic [31:0] ir, input logic con, input logic stop,
                           input logic [26:0] c, input logic [4:0] a);
        vt[nv] = '{ir: ir, con: con, stop: stop, ctl: c, alu: a, run: 1'b1};
        nv++;
    endtask

    task automatic init_prog();
        for (int o = 0; o < 32; o++) begin
            for (int k = 0; k < 8; k++) prog[o][k] = '{ctl: 27'd0, alu: ADD, pc_if_con: 1'b0};
            ps(o, 0, F0, ADD); ps(o, 1, F1, ADD); ps(o, 2, F2, ADD);
            plen[o] = 3;
        end
        for (int o = 3; o <= 11; o++) begin
            ps(o, 3, M_GRB | M_ROUT | M_YIN, ADD);
            ps(o, 4, M_GRC | M_ROUT | M_ZIN, 5'(o));
            ps(o, 5, M_ZLOOUT | M_GRA | M_RIN, ADD);
            plen[o] = 6;
        end
        for (int o = 12; o <= 14; o++) begin
            ps(o, 3, M_GRB | M_ROUT | M_YIN, ADD);
            ps(o, 5, M_ZLOOUT | M_GRA | M_RIN, ADD);
            plen[o] = 6;
        end
        ps(12, 4, M_COUT | M_ZIN, ADD);
        ps(13, 4, M_COUT | M_ZIN, 5'b00101);
        ps(14, 4, M_COUT | M_ZIN, 5'b00110);
        for (int o = 0; o <= 2; o++) begin
            ps(o, 3, M_GRB | M_BAOUT | M_YIN, ADD);
            ps(o, 4, M_COUT | M_ZIN, ADD);
        end
        ps(1, 5, M_ZLOOUT | M_GRA | M_RIN, ADD);                plen[1] = 6;
        ps(0, 5, M_ZLOOUT | M_MARIN, ADD);
        ps(0, 6, M_READ | M_MDRIN, ADD);
        ps(0, 7, M_MDROUT | M_GRA | M_RIN, ADD);                plen[0] = 8;
        ps(2, 5, M_ZLOOUT | M_MARIN, ADD);
        ps(2, 6, M_GRA | M_ROUT | M_MDRIN, ADD);
        ps(2, 7, M_WRITE, ADD);                                 plen[2] = 8;
        for (int o = 15; o <= 16; o++) begin
            ps(o, 3, M_GRA | M_ROUT | M_YIN, ADD);
            ps(o, 4, M_GRB | M_ROUT | M_ZIN, 5'(o));
            ps(o, 5, M_ZLOOUT | M_LOIN, ADD);
            ps(o, 6, M_ZHIOUT | M_HIIN, ADD);
            plen[o] = 7;
        end
        for (int o = 17; o <= 18; o++) begin
            ps(o, 3, M_GRB | M_ROUT | M_ZIN, 5'(o));
            ps(o, 4, M_ZLOOUT | M_GRA | M_RIN, ADD);
            plen[o] = 5;
        end
        ps(19, 3, M_GRA | M_ROUT | M_CONIN, ADD);
        ps(19, 4, M_PCOUT | M_YIN, ADD);
        ps(19, 5, M_COUT | M_ZIN, ADD);
        ps(19, 6, M_ZLOOUT, ADD);
        prog[19][6].pc_if_con = 1'b1;                           plen[19] = 7;
        ps(20, 3, M_PCOUT | M_GRB | M_RIN, ADD);
        ps(20, 4, M_GRA | M_ROUT | M_PCIN, ADD);                plen[20] = 5;
        ps(21, 3, M_GRA | M_ROUT | M_PCIN, ADD);                plen[21] = 4;
        ps(22, 3, M_INPOUT | M_GRA | M_RIN, ADD);               plen[22] = 4;
        ps(23, 3, M_GRA | M_ROUT | M_OUTPIN, ADD);              plen[23] = 4;
        ps(24, 3, M_LOOUT | M_GRA | M_RIN, ADD);                plen[24] = 4;
        ps(25, 3, M_HIOUT | M_GRA | M_RIN, ADD);                plen[25] = 4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  opc;
        logic [31:0] ir, drv;
        logic        c, s, last_s, inj, was_reset;
        logic [26:0] ec;
        int          len, inj_k;

        Reset = 1'b1; Stop = 1'b0; CON = 1'b0; IR = 32'd0;
        init_prog();

        add_vec(ORI_IR, 0, 0, F0, ADD); add_vec(ORI_IR, 0, 0, F1, ADD);
        add_vec(ORI_IR, 0, 0, F2, ADD);
        add_vec(ORI_IR, 0, 0, M_GRB | M_ROUT | M_YIN, ADD);
        add_vec(ORI_IR, 0, 0, M_COUT | M_ZIN, 5'b00110);
        add_vec(ORI_IR, 0, 0, M_ZLOOUT | M_GRA | M_RIN, ADD);
        add_vec(LD_IR, 0, 0, F0, ADD); add_vec(LD_IR, 0, 0, F1, ADD);
        add_vec(LD_IR, 0, 0, F2, ADD);
        add_vec(LD_IR, 0, 0, M_GRB | M_BAOUT | M_YIN, ADD);
        add_vec(LD_IR, 0, 0, M_COUT | M_ZIN, ADD);
        add_vec(LD_IR, 0, 0, M_ZLOOUT | M_MARIN, ADD);
        add_vec(LD_IR, 0, 0, M_READ | M_MDRIN, ADD);
        add_vec(LD_IR, 0, 0, M_MDROUT | M_GRA | M_RIN, ADD);
        for (int pass = 0; pass < 2; pass++) begin
            c = (pass == 0);
            add_vec(BR_IR, c, 0, F0, ADD); add_vec(BR_IR, c, 0, F1, ADD);
            add_vec(BR_IR, c, 0, F2, ADD);
            add_vec(BR_IR, c, 0, M_GRA | M_ROUT | M_CONIN, ADD);
            add_vec(BR_IR, c, 0, M_PCOUT | M_YIN, ADD);
            add_vec(BR_IR, c, 0, M_COUT | M_ZIN, ADD);
            add_vec(BR_IR, c, 0, c ? (M_ZLOOUT | M_PCIN) : M_ZLOOUT, ADD);
        end

        do_reset(2);
        for (int i = 0; i < nv; i++)
            step(vt[i].ir, vt[i].con, vt[i].stop, vt[i].ctl, vt[i].alu, vt[i].run,
                 $sformatf("table_vec%0d", i));

        step(HALT_IR, 0, 0, F0, ADD, 1'b1, "halt_t0");
        step(HALT_IR, 0, 0, F1, ADD, 1'b1, "halt_t1");
        step(HALT_IR, 0, 0, F2, ADD, 1'b1, "halt_t2");
        repeat (20) idle("halt_frozen");
        do_reset(2);

        step(ADD_IR, 0, 0, F0, ADD, 1'b1, "stop_add_t0");
        step(ADD_IR, 0, 0, F1, ADD, 1'b1, "stop_add_t1");
        step(ADD_IR, 0, 0, F2, ADD, 1'b1, "stop_add_t2");
        step(ADD_IR, 0, 0, M_GRB | M_ROUT | M_YIN, ADD, 1'b1, "stop_add_t3");
        step(ADD_IR, 0, 1, M_GRC | M_ROUT | M_ZIN, ADD, 1'b1, "stop_add_t4");
        step(ADD_IR, 0, 1, M_ZLOOUT | M_GRA | M_RIN, ADD, 1'b1, "stop_add_t5");
        repeat (3) idle("stop_halt");
        do_reset(2);

        step(LD_IR, 0, 0, F0, ADD, 1'b1, "rst_ld_t0");
        step(LD_IR, 0, 0, F1, ADD, 1'b1, "rst_ld_t1");
        step(LD_IR, 0, 0, F2, ADD, 1'b1, "rst_ld_t2");
        step(LD_IR, 0, 0, M_GRB | M_BAOUT | M_YIN, ADD, 1'b1, "rst_ld_t3");
        step(LD_IR, 0, 0, M_COUT | M_ZIN, ADD, 1'b1, "rst_ld_t4");
        Reset = 1'b1;
        step(LD_IR, 0, 0, M_ZLOOUT | M_MARIN, ADD, 1'b1, "rst_ld_t5");
        idle("rst_ld_rst");
        Reset = 1'b0;
        idle("rst_ld_release");

        // Random instructions; IR carries the real opcode only during T2.
        for (int n = 0; n < 300; n++) begin
            opc       = 5'($urandom_range(0, 31));
            ir        = {opc, 27'($urandom)};
            len       = plen[opc];
            inj       = ($urandom_range(0, 24) == 0);
            inj_k     = $urandom_range(0, len - 1);
            last_s    = 1'b0;
            was_reset = 1'b0;
            for (int k = 0; k < len; k++) begin
                drv = (k == 2) ? ir : $urandom;
                c   = 1'($urandom);
                s   = ($urandom_range(0, 5) == 0);
                ec  = prog[opc][k].ctl;
                if (prog[opc][k].pc_if_con && c) ec = ec | M_PCIN;
                if (inj && k == inj_k) Reset = 1'b1;
                step(drv, c, s, ec, prog[opc][k].alu, 1'b1,
                     $sformatf("rand%0d_op%0d_t%0d", n, opc, k));
                last_s = s;
                if (inj && k == inj_k) begin
                    idle("rand_mid_reset");
                    Reset = 1'b0;
                    idle("rand_reset_release");
                    was_reset = 1'b1;
                    break;
                end
            end
            if (!was_reset && (opc == 5'd27 || last_s)) begin
                repeat (2) idle("rand_halt");
                do_reset(2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
